// File: rtl/seg7_pkg.sv
// Shared types and the active-low hex segment table for the seven-segment scan driver.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Active-low patterns, bit0 = A ... bit6 = G, indexed by hex value.
  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-segment decoder (active-low outputs).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode display driver: digit store, slot scanning with
// blanking guard, PWM brightness and frame sync, all outputs registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 64,
  parameter int unsigned BRIGHT_W    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  input  logic                          wr_dp,
  input  logic [NUM_DIGITS-1:0]         en_mask,
  input  logic [BRIGHT_W-1:0]           bright,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [6:0]                    seg_n,
  output logic                          dp_n,
  output logic                          frame_tick
);

  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
  localparam int unsigned SlotW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [SlotW-1:0] SlotLast = SlotW'(REFRESH_DIV - 1);
  localparam logic [SlotW-1:0] GuardVal = SlotW'(GUARD);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);

  logic [SlotW-1:0]    slot_cnt_q, slot_cnt_d;
  logic [IdxW-1:0]     digit_idx_q, digit_idx_d;
  logic [BRIGHT_W-1:0] pwm_cnt_q, pwm_cnt_d;

  logic [3:0] val_q [NUM_DIGITS];
  logic       dp_q  [NUM_DIGITS];

  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_q, frame_d;

  logic [3:0] cur_val;
  seg_t       cur_seg;
  logic       guard_ok;
  logic       digit_on;
  logic       wr_ok;

  assign cur_val = val_q[digit_idx_q];

  seg7_hex_decode u_hex_decode (
    .hex_i (cur_val),
    .seg_o (cur_seg)
  );

  assign wr_ok    = wr_en && (32'(wr_addr) < NUM_DIGITS);
  assign guard_ok = (GUARD == 0) || (slot_cnt_q >= GuardVal);
  assign digit_on = en_mask[digit_idx_q] && guard_ok && (pwm_cnt_q <= bright);

  always_comb begin
    slot_cnt_d  = slot_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (slot_cnt_q == SlotLast) begin
      slot_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == IdxLast) ? '0 : digit_idx_q + 1'b1;
    end
    pwm_cnt_d = pwm_cnt_q + 1'b1;
  end

  // Outputs are computed from this cycle's counters/store and appear next cycle.
  always_comb begin
    an_d    = '1;
    seg_d   = SEG_BLANK;
    dp_n_d  = 1'b1;
    frame_d = (slot_cnt_q == '0) && (digit_idx_q == '0);
    if (digit_on) begin
      an_d[digit_idx_q] = 1'b0;
      seg_d             = cur_seg;
      dp_n_d            = ~dp_q[digit_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      pwm_cnt_q   <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      dp_n_q      <= 1'b1;
      frame_q     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        val_q[i] <= 4'h0;
        dp_q[i]  <= 1'b0;
      end
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      pwm_cnt_q   <= pwm_cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_n_q      <= dp_n_d;
      frame_q     <= frame_d;
      if (wr_ok) begin
        val_q[wr_addr] <= wr_data;
        dp_q[wr_addr]  <= wr_dp;
      end
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_n_q;
  assign frame_tick = frame_q;

endmodule
